ps2_kbd_rx: RTL
===============

Name: ps2_kbd_rx

Overview:
Parametrised PS/2 keyboard receiver for the NPC peripheral set.
- Samples ps2_clk/ps2_data and validates 11-bit frames.
- Folds the E0 (extended) and F0 (break) prefix bytes into flags on the following scan code.
- Queues decoded key events in a FIFO of configurable depth, read with a ready/nextdata_n handshake.
- Adds a frame-error flag, an inactivity timeout for resync, and a sticky overflow flag.

Parameters:
FIFO_DEPTH, 8, number of queued key events; power of 2, >= 2
TIMEOUT_CYCLES, 50000, clk cycles without a ps2_clk falling edge before a partial frame is discarded
SYNC_STAGES, 3, synchroniser depth for ps2_clk and ps2_data; >= 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
ps2_clk  in  1  raw PS/2 clock (asynchronous)
ps2_data  in  1  raw PS/2 data (asynchronous)
nextdata_n  in  1  active-low pop request; honoured only while ready=1
ready  out  1  FIFO non-empty; head entry valid on code/brk/ext
code  out  8  head scan code
brk  out  1  head entry was preceded by F0
ext  out  1  head entry was preceded by E0
overflow  out  1  sticky; an event was dropped because the FIFO was full
overflow_clr  in  1  synchronous clear of overflow
frame_err  out  1  one-cycle pulse on a bad frame or timeout

Behaviour:
- Reset (rst=0 at posedge clk): bit counter, FIFO pointers, prefix flags, timeout counter and sync chain cleared. ready=0, overflow=0, frame_err=0. code/brk/ext are don't-care while ready=0. Reset mid-frame discards the partial frame.
- Sampling: ps2_clk and ps2_data pass through SYNC_STAGES flops. A falling edge is sync[last]=1 and sync[last-1]=0. Data is sampled from the synchronised ps2_data in the same cycle.
- Frame FSM (counter 0..10): IDLE(0) -> RECV(1..9) -> STOP(10). One bit is captured per falling edge.
  - At count 10 the frame is checked: start=0, stop=1, odd parity over the 8 data bits plus the parity bit.
  - The counter returns to 0 whether the check passes or fails.
- Valid byte handling:
  - E0: set ext_pend; no push.
  - F0: set brk_pend; no push.
  - Any other byte: push {ext_pend, brk_pend, byte}, then clear both pending flags.
  - A push that is dropped (FIFO full) also clears the pending flags.
- Invalid frame: frame_err pulses one cycle, nothing is pushed, and both pending flags clear.
- Timeout: while count != 0, a counter runs and resets on each falling edge. On reaching TIMEOUT_CYCLES-1: count->0, frame_err pulses, pending flags are kept.
- Latency: the FIFO write occurs at the clk edge ending the stop-bit sampling cycle. ready=1 from the next cycle.
- Read: ready=1 and nextdata_n=0 at a posedge pops the head. The new head (or ready=0) is visible the next cycle. nextdata_n is ignored when empty.
- Full: a push with the FIFO full and no simultaneous pop is dropped and overflow is set.
- Full with a simultaneous pop and push: both are accepted, overflow is unchanged, occupancy stays full.
- overflow: set has priority over overflow_clr in the same cycle.
- Pointers: log2(FIFO_DEPTH)+1 bits with a wrap bit. Empty when the pointers are equal; full when they differ only in the MSB.

Decomposition:
- Package ps2_pkg:
  - PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BRK=8'hF0.
  - Frame length constant 11.
  - Typedef ps2_evt_t {ext, brk, code[7:0]} (10 bits).
- Sub-module sync_fifo, parametrised on width and depth, holding ps2_evt_t. It provides full/empty, push/pop and simultaneous-op rules as above.
- Synchroniser, edge detect, frame FSM, prefix flags and timeout stay in ps2_kbd_rx.

Test Plan:
1. Single frame 0x1C, good parity, no reads -> ready=1 one cycle after stop sample; code=0x1C, brk=0, ext=0. Pop -> ready=0 next cycle.
2. Frames F0,1C then E0,F0,75 -> exactly two entries: {0,1,1C} then {1,1,75}. Pops return them in order.
3. Frame 0x1C with wrong parity, then 0x1C with good parity, and separately a frame with stop=0 -> frame_err pulse on each bad frame, no entry pushed. Preceding F0 pending is cleared, so the next 0x1C arrives with brk=0.
4. FIFO_DEPTH=8, push 9 codes 0x01..0x09 without reads -> overflow=1. Pops return 0x01..0x08, then ready=0. overflow_clr -> overflow=0.
5. Full FIFO, pop asserted in the same cycle as the 9th push -> overflow stays 0. Contents are 0x02..0x09.
6. 5 bits of a frame, then idle for TIMEOUT_CYCLES -> frame_err pulse, counter resync. The next full frame 0x5A is received correctly. Assert rst mid-frame -> all outputs return to reset values.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam int         PS2_FRAME_LEN  = 11;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_STOP
    } ps2_state_e;

    // start=0, stop=1, odd parity across data and parity bit
    function automatic logic ps2_frame_ok(
        input logic [PS2_FRAME_LEN-1:0] f
    );
        return !f[0] && f[PS2_FRAME_LEN-1] && (^f[9:1]);
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push with full is dropped unless a pop frees a slot.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             dropped
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (wr_q == rd_q);
        full    = (wr_q[AW] != rd_q[AW]) &&
                  (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dropped = push && full && !do_pop;
        rdata   = mem_q[rd_q[AW-1:0]];
        wr_d    = wr_q;
        rd_d    = rd_q;
        mem_d   = mem_q;
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = wdata;
            wr_d = wr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_d = rd_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: sync, frame check, E0/F0 folding, event FIFO.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic       ready,
    output logic [7:0] code,
    output logic       brk,
    output logic       ext,
    output logic       overflow,
    input  logic       overflow_clr,
    output logic       frame_err
);

    localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_ONE  = TW'(1);

    logic [SYNC_STAGES-1:0] kclk_q, kclk_d;
    logic [SYNC_STAGES-1:0] kdat_q, kdat_d;
    ps2_state_e             state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [9:0]             sr_q, sr_d;
    logic                   ext_pend_q, ext_pend_d;
    logic                   brk_pend_q, brk_pend_d;
    logic [TW-1:0]          to_q, to_d;
    logic                   err_q, err_d;
    logic                   ovf_q, ovf_d;

    logic                   fall;
    logic                   bit_in;
    logic                   timeout;
    logic [PS2_FRAME_LEN-1:0] frame;
    logic [7:0]             rx_byte;
    logic                   push;
    ps2_evt_t               push_evt;
    ps2_evt_t               head;
    logic [$bits(ps2_evt_t)-1:0] head_raw;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   fifo_drop;

    always_comb begin
        kclk_d  = {kclk_q[SYNC_STAGES-2:0], ps2_clk};
        kdat_d  = {kdat_q[SYNC_STAGES-2:0], ps2_data};
        fall    = kclk_q[SYNC_STAGES-1] && !kclk_q[SYNC_STAGES-2];
        bit_in  = kdat_q[SYNC_STAGES-1];
        frame   = {bit_in, sr_q};
        rx_byte = frame[8:1];
    end

    // Watchdog only runs mid-frame; any falling edge restarts it
    always_comb begin
        timeout = 1'b0;
        if (state_q == ST_IDLE || fall) begin
            to_d = '0;
        end else if (to_q == TO_LAST) begin
            to_d    = '0;
            timeout = 1'b1;
        end else begin
            to_d = to_q + TO_ONE;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        err_d      = 1'b0;
        push       = 1'b0;
        push_evt   = '{ext: ext_pend_q, brk: brk_pend_q, code: rx_byte};
        if (timeout) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
        end else if (fall) begin
            unique case (state_q)
                ST_IDLE: begin
                    sr_d    = {bit_in, sr_q[9:1]};
                    cnt_d   = 4'd1;
                    state_d = ST_RECV;
                end
                ST_RECV: begin
                    sr_d  = {bit_in, sr_q[9:1]};
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd9) begin
                        state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (ps2_frame_ok(frame)) begin
                        unique case (1'b1)
                            (rx_byte == PS2_PREFIX_EXT): ext_pend_d = 1'b1;
                            (rx_byte == PS2_PREFIX_BRK): brk_pend_d = 1'b1;
                            default: begin
                                push       = 1'b1;
                                ext_pend_d = 1'b0;
                                brk_pend_d = 1'b0;
                            end
                        endcase
                    end else begin
                        err_d      = 1'b1;
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (fifo_drop) begin
            ovf_d = 1'b1;
        end else if (overflow_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            kclk_q     <= '0;
            kdat_q     <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            to_q       <= '0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            kclk_q     <= kclk_d;
            kdat_q     <= kdat_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            to_q       <= to_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH($bits(ps2_evt_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wdata  (push_evt),
        .pop    (!nextdata_n),
        .rdata  (head_raw),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .dropped(fifo_drop)
    );

    always_comb begin
        head      = ps2_evt_t'(head_raw);
        ready     = !fifo_empty;
        code      = head.code;
        brk       = head.brk;
        ext       = head.ext;
        overflow  = ovf_q;
        frame_err = err_q;
    end

endmodule
